// File: rtl/nbr_conflict_sched_if.sv
// Handshake and data bundle between the colour bank / sequencer and nbr_conflict_sched.
interface nbr_conflict_sched_if #(
  parameter int NUM_NODES = 4,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 3
);
  logic                           start;
  logic [2*NUM_NODES-1:0]         colors;
  logic [4*IDX_W*NUM_NODES-1:0]   nbr_idx;
  logic [4*NUM_NODES-1:0]         nbr_vld;
  logic                           busy;
  logic                           done;
  logic [NUM_NODES-1:0]           conflict;
  logic [CNT_W-1:0]               conflict_cnt;

  modport master (
    output start, colors, nbr_idx, nbr_vld,
    input  busy, done, conflict, conflict_cnt
  );

  modport slave (
    input  start, colors, nbr_idx, nbr_vld,
    output busy, done, conflict, conflict_cnt
  );
endinterface

// File: rtl/nbr_conflict_sched.sv
// Time-shared neighbour colour-conflict scanner; one 2-bit comparator walks every node's 4 slots.
// Define NBR_EARLY_EXIT_EN to stop scanning a node at its first hit.
//
// state | meaning
// IDLE  | waiting for start; results held
// LOAD  | latch own colour of node ptr
// CMP   | compare one neighbour slot per cycle
// DONE  | one-cycle done pulse
module nbr_conflict_sched #(
  parameter int NUM_NODES = 4,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst,
  nbr_conflict_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CMP, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_NODES - 1);
  localparam logic [IDX_W:0]   NODES_L = (IDX_W + 1)'(NUM_NODES);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [1:0]           slot;
  logic [1:0]           own_col;
  logic [NUM_NODES-1:0] conflict;
  logic [CNT_W-1:0]     conflict_cnt;
  logic [IDX_W-1:0]     nbr;
  logic                 hit;
  logic                 node_end;

  logic [IDX_W-1:0] idx_arr [NUM_NODES*4];
  logic [1:0]       col_arr [2**IDX_W];

  for (genvar g = 0; g < NUM_NODES*4; g++) begin : g_idx
    assign idx_arr[g] = bus.nbr_idx[g*IDX_W +: IDX_W];
  end

  // Unused index codes read as colour 0; the range check keeps them from hitting.
  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_col
    if (g < NUM_NODES) begin : g_real
      assign col_arr[g] = bus.colors[2*g +: 2];
    end else begin : g_pad
      assign col_arr[g] = 2'b00;
    end
  end

  assign nbr = idx_arr[{ptr, slot}];
  assign hit = (state == CMP) && bus.nbr_vld[{ptr, slot}] && (nbr != ptr)
               && ({1'b0, nbr} < NODES_L) && (col_arr[nbr] == own_col);

`ifdef NBR_EARLY_EXIT_EN
  assign node_end = (slot == 2'd3) || hit;
`else
  assign node_end = (slot == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = CMP;
      CMP:     if (node_end) state_nxt = (ptr == LAST) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr          <= '0;
      slot         <= '0;
      own_col      <= '0;
      conflict     <= '0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            conflict     <= '0;
            conflict_cnt <= '0;
            ptr          <= '0;
          end
        end
        LOAD: begin
          own_col <= col_arr[ptr];
          slot    <= '0;
        end
        CMP: begin
          // Count only the first hit per node so the count equals popcount(conflict).
          if (hit && !conflict[ptr]) begin
            conflict[ptr] <= 1'b1;
            conflict_cnt  <= conflict_cnt + CNT_W'(1);
          end
          if (node_end) begin
            slot <= '0;
            if (ptr != LAST) ptr <= ptr + IDX_W'(1);
          end else begin
            slot <= slot + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.conflict     = conflict;
  assign bus.conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_nbr_conflict_sched.sv
// Self-checking bench for nbr_conflict_sched: directed cases plus random scans against a behavioural model.
module tb_nbr_conflict_sched;
  localparam int N = 4, IW = 2, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nbr_conflict_sched_if #(.NUM_NODES(N), .IDX_W(IW), .CNT_W(CW)) bif ();
  nbr_conflict_sched #(.NUM_NODES(N), .IDX_W(IW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  // Three-node instance exercises the out-of-range index masking.
  nbr_conflict_sched_if #(.NUM_NODES(3), .IDX_W(2), .CNT_W(3)) bif3 ();
  nbr_conflict_sched #(.NUM_NODES(3), .IDX_W(2), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bif3)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] m_col [4];
  logic [1:0] m_idx [4][4];
  logic       m_vld [4][4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a node conflicts if any valid, non-self, in-range neighbour shares its colour.
  function automatic void model(input int n, output logic [3:0] conf, output int cnt, output int lat);
    int  used;
    int  k;
    bit  h;
    conf = '0;
    cnt  = 0;
    lat  = 1;
    for (int i = 0; i < n; i++) begin
      used = 4;
      h    = 1'b0;
      for (int j = 0; j < 4; j++) begin
        k = int'(m_idx[i][j]);
        if (m_vld[i][j] && k != i && k < n && m_col[k] == m_col[i]) begin
          if (!h) used = j + 1;
          h = 1'b1;
        end
      end
      conf[i] = h;
      cnt += int'(h);
`ifdef NBR_EARLY_EXIT_EN
      lat += 1 + used;
`else
      lat += 5;
`endif
    end
  endfunction

  task automatic ring_setup();
    for (int i = 0; i < 4; i++) begin
      m_idx[i][0] = 2'((i + 1) % 4);
      m_idx[i][1] = 2'((i + 3) % 4);
      m_idx[i][2] = 2'(i);
      m_idx[i][3] = 2'((i + 2) % 4);
      m_vld[i][0] = 1'b1;
      m_vld[i][1] = 1'b1;
      m_vld[i][2] = 1'b0;
      m_vld[i][3] = 1'b0;
    end
  endtask

  task automatic drive_main();
    for (int i = 0; i < 4; i++) begin
      bif.colors[2*i +: 2] = m_col[i];
      for (int j = 0; j < 4; j++) begin
        bif.nbr_idx[(4*i + j)*2 +: 2] = m_idx[i][j];
        bif.nbr_vld[4*i + j]          = m_vld[i][j];
      end
    end
  endtask

  // Runs one scan, checking busy/done on every cycle and results at the done cycle.
  task automatic run_scan(input bit b2b, input int busy_start_cyc,
                          output logic [3:0] conf_o, output int lat_o);
    logic [3:0] conf;
    int cnt, lat;
    model(4, conf, cnt, lat);
    if (!b2b) @(negedge clk);
    drive_main();
    bif.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      bif.start = (c == busy_start_cyc) && (c <= lat);
      check("busy", 32'(bif.busy), 32'(c <= lat));
      check("done", 32'(bif.done), 32'(c == lat));
      if (c >= lat) begin
        check("conflict", 32'(bif.conflict), 32'(conf));
        check("conflict_cnt", 32'(bif.conflict_cnt), 32'(cnt));
      end
    end
    bif.start = 1'b0;
    conf_o = conf;
    lat_o  = lat;
  endtask

  logic [3:0] conf;
  int lat, cnt;

  initial begin
    bif.start   = 1'b0;
    bif.colors  = '0;
    bif.nbr_idx = '0;
    bif.nbr_vld = '0;
    bif3.start   = 1'b0;
    bif3.colors  = '0;
    bif3.nbr_idx = '0;
    bif3.nbr_vld = '0;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(bif.busy), 32'd0);
      check("idle_done", 32'(bif.done), 32'd0);
      check("idle_conflict", 32'(bif.conflict), 32'd0);
      check("idle_cnt", 32'(bif.conflict_cnt), 32'd0);
    end

    // Proper colouring on a ring.
    m_col[0] = 2'd0; m_col[1] = 2'd1; m_col[2] = 2'd2; m_col[3] = 2'd3;
    ring_setup();
    run_scan(1'b0, 0, conf, lat);
    check("proper_pin_conf", 32'(conf), 32'd0);
    check("proper_pin_lat", 32'(lat), 32'd21);

    // Start during a scan is ignored.
    run_scan(1'b0, 5, conf, lat);
    check("busy_start_lat", 32'(lat), 32'd21);

    // Single clash, launched back-to-back in the cycle after done.
    m_col[1] = 2'd0;
    run_scan(1'b1, 0, conf, lat);
    check("clash_pin_conf", 32'(conf), 32'h3);
    check("clash_dut_conflict", 32'(bif.conflict), 32'h3);
    check("clash_dut_cnt", 32'(bif.conflict_cnt), 32'd2);
`ifdef NBR_EARLY_EXIT_EN
    check("clash_pin_lat_early", 32'(lat), 32'd16);
`else
    check("clash_pin_lat", 32'(lat), 32'd21);
`endif

    // Reset mid-scan discards the partial result.
    @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_mid_busy", 32'(bif.busy), 32'd0);
    check("rst_mid_done", 32'(bif.done), 32'd0);
    check("rst_mid_conflict", 32'(bif.conflict), 32'd0);
    check("rst_mid_cnt", 32'(bif.conflict_cnt), 32'd0);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(bif.done), 32'd0);
    end
    run_scan(1'b0, 0, conf, lat);
    check("rst_follow_conf", 32'(bif.conflict), 32'h3);

    // Random scans.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 4; i++) begin
        m_col[i] = 2'($urandom_range(0, 3));
        for (int j = 0; j < 4; j++) begin
          m_idx[i][j] = 2'($urandom_range(0, 3));
          m_vld[i][j] = 1'($urandom_range(0, 1));
        end
      end
      run_scan(1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 21)) : 0, conf, lat);
    end

    // Masking on the three-node instance: every slot invalid, self or index 3.
    for (int t = 0; t < 3; t++) begin
      int seen;
      for (int i = 0; i < 4; i++) m_col[i] = 2'd2;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 4; j++) begin
          case ($urandom_range(0, 2))
            0:       begin m_vld[i][j] = 1'b0; m_idx[i][j] = 2'($urandom_range(0, 3)); end
            1:       begin m_vld[i][j] = 1'b1; m_idx[i][j] = 2'(i); end
            default: begin m_vld[i][j] = 1'b1; m_idx[i][j] = 2'd3; end
          endcase
        end
      end
      model(3, conf, cnt, lat);
      check("mask_pin_conf", 32'(conf), 32'd0);
      check("mask_pin_lat", 32'(lat), 32'd16);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bif3.colors[2*i +: 2] = m_col[i];
        for (int j = 0; j < 4; j++) begin
          bif3.nbr_idx[(4*i + j)*2 +: 2] = m_idx[i][j];
          bif3.nbr_vld[4*i + j]          = m_vld[i][j];
        end
      end
      bif3.start = 1'b1;
      @(negedge clk);
      bif3.start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 60 && seen == 0; c++) begin
        if (c > 1) @(negedge clk);
        if (bif3.done === 1'b1) seen = c;
      end
      check("mask_lat", 32'(seen), 32'(lat));
      check("mask_conflict", 32'(bif3.conflict), 32'd0);
      check("mask_cnt", 32'(bif3.conflict_cnt), 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
